// File: rtl/motor_seq_pkg.sv
// Shared definitions for the motor drive sequencer.
//   state_e    : sequencer states
//   *_DEF      : default parameter values for the top level
//   DEAD_CNT_W : dead-time counter width for the default DEAD_PER
package motor_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_BRAKE,
        ST_DEAD,
        ST_FAULT
    } state_e;

    localparam int DUTY_W_DEF    = 8;
    localparam int PRESCALE_DEF  = 78;
    localparam int RAMP_STEP_DEF = 16;
    localparam int DEAD_PER_DEF  = 4;
    localparam int DEAD_CNT_W    = $clog2(DEAD_PER_DEF + 1);

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler dividing clk down to PWM counts, and a free
// running DUTY_W-bit PWM counter.
//   clk, reset  : system clock, async active-high reset
//   pwm_cnt     : current PWM count, 0 .. 2**DUTY_W-1
//   period_tick : high for the single clk cycle whose edge wraps pwm_cnt to 0
module pwm_timebase #(
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 78
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DUTY_W-1:0] pwm_cnt,
    output logic              period_tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              presc_wrap;

    always_comb begin
        presc_wrap  = (presc_q == PS_MAX);
        presc_d     = presc_wrap ? '0 : presc_q + PS_W'(1);
        // pwm count wraps naturally at 2**DUTY_W
        cnt_d       = presc_wrap ? cnt_q + DUTY_W'(1) : cnt_q;
        period_tick = presc_wrap && (cnt_q == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_cnt = cnt_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// Motor H-bridge drive sequencer. Takes (duty, direction) set-points over a
// valid/ready handshake, slews the applied duty once per PWM period, and
// reverses safely: ramp down, hold EN low for DEAD_PER periods, flip DIR,
// ramp up. estop forces FAULT with EN low.
//   cmd_valid/cmd_ready/cmd_duty/cmd_dir : set-point handshake
//   estop       : level emergency stop
//   EN, DIR     : H-bridge drive pins (EN registered)
//   duty_cur    : duty currently applied
//   busy        : reversal in progress (BRAKE or DEAD)
//   fault       : in FAULT
//   period_tick : one-cycle pulse at PWM counter wrap
module motor_drive_sequencer
    import motor_seq_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int PRESCALE  = PRESCALE_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int DEAD_PER  = DEAD_PER_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_dir,
    input  logic              estop,
    output logic              EN,
    output logic              DIR,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              busy,
    output logic              fault,
    output logic              period_tick
);

    localparam int DCW = $clog2(DEAD_PER + 1);
    localparam logic [DCW-1:0]  DEAD_LAST = DCW'(DEAD_PER - 1);
    localparam logic [DUTY_W:0] STEP      = (DUTY_W + 1)'(RAMP_STEP);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] tgt_duty_q, tgt_duty_d;
    logic              tgt_dir_q, tgt_dir_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic [DCW-1:0]    dead_q, dead_d;
    logic              en_q, en_d;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              accept;

    pwm_timebase #(.DUTY_W(DUTY_W), .PRESCALE(PRESCALE)) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .pwm_cnt    (pwm_cnt),
        .period_tick(period_tick)
    );

    // One slew step toward tgt, computed one bit wider so neither the
    // upward add nor the downward subtract can wrap.
    function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] lim;
        up  = {1'b0, cur} + STEP;
        lim = {1'b0, tgt} + STEP;
        if (cur < tgt)
            slew = (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        else if (lim <= {1'b0, cur})
            slew = cur - STEP[DUTY_W-1:0];
        else
            slew = tgt;
    endfunction

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_FAULT);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d    = state_q;
        tgt_duty_d = tgt_duty_q;
        tgt_dir_d  = tgt_dir_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        dead_d     = dead_q;

        if (estop) begin
            state_d    = ST_FAULT;
            duty_d     = '0;
            tgt_duty_d = '0;
            dead_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    if (accept) begin
                        tgt_duty_d = cmd_duty;
                        tgt_dir_d  = cmd_dir;
                        if (cmd_dir != dir_q) begin
                            state_d = ST_DEAD;
                            dead_d  = '0;
                        end else if (cmd_duty != '0) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // slew uses the target held before any same-cycle accept
                    if (period_tick)
                        duty_d = slew(duty_q, tgt_duty_q);
                    if (accept) begin
                        tgt_duty_d = cmd_duty;
                        tgt_dir_d  = cmd_dir;
                        if (cmd_dir != dir_q) begin
                            if (duty_q == '0) begin
                                // already stopped: hold 0 even if a tick would ramp
                                state_d = ST_DEAD;
                                dead_d  = '0;
                                duty_d  = '0;
                            end else begin
                                state_d = ST_BRAKE;
                            end
                        end
                    end else if (duty_q == '0 && tgt_duty_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRAKE: begin
                    if (period_tick)
                        duty_d = slew(duty_q, '0);
                    if (duty_q == '0) begin
                        state_d = ST_DEAD;
                        dead_d  = '0;
                    end
                end
                ST_DEAD: begin
                    if (period_tick) begin
                        if (dead_q == DEAD_LAST) begin
                            dead_d  = '0;
                            dir_d   = tgt_dir_q;
                            state_d = (tgt_duty_q != '0) ? ST_RUN : ST_IDLE;
                        end else begin
                            dead_d = dead_q + DCW'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    // set-points are swallowed; only a zero-duty command clears
                    duty_d = '0;
                    if (accept && cmd_duty == '0)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        en_d = (pwm_cnt < duty_q) && (state_q != ST_FAULT) && !estop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tgt_duty_q <= '0;
            tgt_dir_q  <= 1'b0;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            dead_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            dead_q     <= dead_d;
            en_q       <= en_d;
        end
    end

    assign EN       = en_q;
    assign DIR      = dir_q;
    assign duty_cur = duty_q;
    assign busy     = (state_q == ST_BRAKE) || (state_q == ST_DEAD);
    assign fault    = (state_q == ST_FAULT);

endmodule
